interval_arbiter: RTL and testbench
===================================

INTERVAL_ARBITER -- requirements
Module: interval_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, interval counter width in bits.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_i  input  N_REQ  per-requester request, level, held until done_o or withdrawn.
REQ-006 SHALL have port len_i  input  N_REQ x WIDTH  per-requester interval length in cycles.
REQ-007 SHALL have port grant_o  output  N_REQ  one-hot grant, zero when idle.
REQ-008 SHALL have port done_o  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-009 SHALL have port busy_o  output  1  high in RUN and DONE states.
REQ-010 SHALL have port count_o  output  WIDTH  current interval count.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-012 IDLE: if any req_i bit set, SHALL select winner round-robin, latch L = max(len_i[winner], 1), clear count to 0, enter RUN next cycle; else stay IDLE.
REQ-013 Round-robin: search SHALL start at (last_winner+1) mod N_REQ; last_winner after reset = N_REQ-1, so requester 0 has first priority.
REQ-014 RUN: grant_o SHALL be one-hot for the winner; count_o SHALL increment by 1 per cycle, showing 0..L-1.
REQ-015 RUN SHALL last exactly L cycles; on the cycle count_o == L-1, transition to DONE.
REQ-016 DONE: SHALL last 1 cycle, with done_o[winner]=1, grant_o=0, and count_o held at L-1; then IDLE.
REQ-017 Latency: a request seen in IDLE at cycle t SHALL yield grant_o at t+1..t+L, done_o at t+L+1, and IDLE at t+L+2.
REQ-018 Abort: if req_i[winner] falls during RUN, SHALL go to IDLE next cycle, with no done_o pulse, count_o cleared to 0, and last_winner still updated.
REQ-019 Changes to len_i after latching SHALL NOT affect the active interval.
REQ-020 Request bits of non-winners during RUN/DONE SHALL be ignored, not queued; arbitration happens only in IDLE.
REQ-021 len_i = 0 SHALL be treated as 1; len_i = 2^WIDTH-1 SHALL run 2^WIDTH-1 cycles with no counter wrap.
REQ-022 A requester holding req_i high through done_o SHALL be re-arbitrated in the following IDLE cycle at lowest priority.

Reset
REQ-023 On rst_i high at a clock edge: state=IDLE, grant_o=0, done_o=0, busy_o=0, count_o=0, last_winner=N_REQ-1.
REQ-024 Reset mid-RUN or mid-DONE SHALL abort without a done_o pulse; rst_i SHALL override all other inputs.

Structure
REQ-025 Package interval_arbiter_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default constants N_REQ_DEF=4 and WIDTH_DEF=8.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: req, last_winner; outputs: one-hot grant, index, valid).

Verification
REQ-027 Reset, then req_i=0001 with len_i[0]=3 -> grant_o=0001 for 3 cycles, count_o 0,1,2, done_o=0001 on the 4th cycle after request, busy_o=0 after.
REQ-028 req_i=1111 held, all len=2 -> grants in order 0001, 0010, 0100, 1000, 0001, each followed by a done pulse; period 4 cycles per grant.
REQ-029 len_i[2]=0, req_i=0100 -> a 1-cycle RUN with count_o=0, then done_o=0100.
REQ-030 Grant to requester 1 with len=10; drop req_i[1] at count_o=4 -> IDLE next cycle, no done_o, count_o=0.
REQ-031 rst_i asserted at count_o=5 of a len=8 interval -> all outputs 0 next cycle; next request from 0 and 3 together -> grant 0001.
REQ-032 WIDTH=8, len=255 -> exactly 255 RUN cycles, count_o peaks at 254, no wrap, done_o once.

Source files
------------

// File: rtl/interval_arbiter_pkg.sv
// Shared types and defaults for the interval arbiter.
package interval_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/interval_arbiter_rr.sv
// Combinational round-robin selector: searches from last_winner+1 upward, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last_winner,
  output logic [N_REQ-1:0] grant,
  output logic [IDXW-1:0]  index,
  output logic             valid
);

  logic [IDXW-1:0] cand;

  // first set request at or after last_winner+1 (mod N_REQ) wins
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDXW'((int'(last_winner) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        index       = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_arbiter.sv
// Grants one requester for a latched interval of L cycles, then pulses done.
// Arbitration only happens in IDLE; dropping the request mid-interval aborts it.
module interval_arbiter
  import interval_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0][WIDTH-1:0] len_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [N_REQ-1:0]            done_o,
  output logic                        busy_o,
  output logic [WIDTH-1:0]            count_o
);

  localparam int IDXW = $clog2(N_REQ);

  state_t            state, state_next;
  logic [WIDTH-1:0]  len_lat, len_next, count_next, len_sel;
  logic [IDXW-1:0]   winner, winner_next, last_winner, last_next, arb_index;
  logic [N_REQ-1:0]  arb_grant, grant_next, done_next;
  logic              arb_valid, busy_next;

  rr_arbiter #(.N_REQ(N_REQ), .IDXW(IDXW)) u_rr (
    .req         (req_i),
    .last_winner (last_winner),
    .grant       (arb_grant),
    .index       (arb_index),
    .valid       (arb_valid)
  );

  assign len_sel = len_i[arb_index];

  // next-state and next-output computation
  always_comb begin
    state_next  = state;
    grant_next  = grant_o;
    done_next   = '0;
    count_next  = count_o;
    len_next    = len_lat;
    winner_next = winner;
    last_next   = last_winner;
    case (state)
      IDLE: begin
        grant_next = '0;
        count_next = '0;
        if (arb_valid) begin
          state_next  = RUN;
          grant_next  = arb_grant;
          len_next    = (len_sel == '0) ? WIDTH'(1) : len_sel;
          winner_next = arb_index;
          last_next   = arb_index;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        // a withdrawn request takes precedence over normal completion
        if (!req_i[winner]) begin
          state_next = IDLE;
          grant_next = '0;
          count_next = '0;
        end else if (count_o == len_lat - WIDTH'(1)) begin
          state_next = DONE;
          grant_next = '0;
          done_next  = grant_o;
        end else begin
          count_next = count_o + WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        count_next = '0;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        count_next = '0;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      grant_o     <= '0;
      done_o      <= '0;
      busy_o      <= 1'b0;
      count_o     <= '0;
      len_lat     <= WIDTH'(1);
      winner      <= '0;
      last_winner <= IDXW'(N_REQ - 1);
    end else begin
      state       <= state_next;
      grant_o     <= grant_next;
      done_o      <= done_next;
      busy_o      <= busy_next;
      count_o     <= count_next;
      len_lat     <= len_next;
      winner      <= winner_next;
      last_winner <= last_next;
    end
  end

endmodule

// File: tb/tb_interval_arbiter.sv
// Randomized scoreboard bench: the stimulus side predicts each grant episode,
// a negedge monitor reconstructs episodes from the DUT outputs and compares.
module tb_interval_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] len;
  logic [N-1:0]        grant_o, done_o;
  logic                busy_o;
  logic [W-1:0]        count_o;

  interval_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .len_i   (len),
    .grant_o (grant_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {int w; int n; bit done;} exp_t;
  exp_t exp_q[$];

  int  compared   = 0;
  int  mismatched = 0;
  int  model_last = N - 1;
  bit  mon_en     = 1'b0;
  bit  active     = 1'b0;
  int  gw, n_seen;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int eff_len(input logic [N-1:0][W-1:0] lv, input int w);
    return (lv[w] == '0) ? 1 : int'(lv[w]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // activity the DUT must ignore while an interval is running
  task automatic scramble(input int w);
    req    = N'($urandom);
    req[w] = 1'b1;
    for (int i = 0; i < N; i++) len[i] = W'($urandom);
  endtask

  // one arbitration; cut<0 runs to completion, else stops after count_o==cut
  task automatic txn(input logic [N-1:0] rv, input logic [N-1:0][W-1:0] lv,
                     input int cut, input bit by_reset);
    int   w, l;
    exp_t e;
    req = rv;
    len = lv;
    w   = rr(rv, model_last);
    if (w < 0) begin
      step();
      return;
    end
    l          = eff_len(lv, w);
    model_last = w;
    e.w        = w;
    e.n        = (cut < 0) ? l : cut + 1;
    e.done     = (cut < 0);
    exp_q.push_back(e);
    step();
    if (cut < 0) begin
      repeat (l) begin
        scramble(w);
        step();
      end
      scramble(w);
      step();
    end else begin
      repeat (cut) begin
        scramble(w);
        step();
      end
      if (by_reset) begin
        rst = 1'b1;
        step();
        rst        = 1'b0;
        model_last = N - 1;
      end else begin
        scramble(w);
        req[w] = 1'b0;
        step();
      end
    end
  endtask

  // episode reconstruction from DUT outputs
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (grant_o != '0) begin
        if (!active) begin
          active = 1'b1;
          n_seen = 0;
          gw     = 0;
          for (int i = N - 1; i >= 0; i--) if (grant_o[i]) gw = i;
          chk("grant_onehot", $countones(grant_o), 1);
        end
        chk("grant_stable", int'(grant_o), 1 << gw);
        chk("count_run", int'(count_o), n_seen);
        chk("busy_run", int'(busy_o), 1);
        n_seen++;
      end else if (active) begin
        active = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_episode", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("winner", gw, e.w);
          chk("grant_cycles", n_seen, e.n);
          chk("done_seen", int'(done_o != '0), int'(e.done));
          if (e.done) begin
            chk("done_onehot", int'(done_o), 1 << e.w);
            chk("count_done", int'(count_o), e.n - 1);
            chk("busy_done", int'(busy_o), 1);
          end else begin
            chk("count_abort", int'(count_o), 0);
            chk("busy_abort", int'(busy_o), 0);
          end
        end
      end else begin
        chk("idle_done", int'(done_o), 0);
        chk("idle_busy", int'(busy_o), 0);
      end
    end
  end

  initial begin
    logic [N-1:0][W-1:0] lv;
    logic [N-1:0]        rv;
    int                  w, l, cut;
    bit                  by_rst;

    rst = 1'b1;
    req = '0;
    len = '0;
    repeat (3) step();
    chk("reset_grant", int'(grant_o), 0);
    chk("reset_done", int'(done_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_count", int'(count_o), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    lv = '0; lv[0] = W'(3);
    txn(4'b0001, lv, -1, 1'b0);
    req = '0;
    repeat (2) step();

    // restart round-robin from requester 0 for the all-request rotation
    rst = 1'b1; step(); rst = 1'b0; model_last = N - 1;
    for (int i = 0; i < N; i++) lv[i] = W'(2);
    repeat (5) txn(4'b1111, lv, -1, 1'b0);

    lv = '0;
    txn(4'b0100, lv, -1, 1'b0);

    lv = '0; lv[1] = W'(10);
    txn(4'b0010, lv, 4, 1'b0);

    lv = '0; lv[0] = W'(8);
    txn(4'b0001, lv, 5, 1'b1);
    lv = '0; lv[0] = W'(2); lv[3] = W'(2);
    txn(4'b1001, lv, -1, 1'b0);

    lv = '0; lv[2] = W'(255);
    txn(4'b0100, lv, -1, 1'b0);

    repeat (150) begin
      rv = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) lv[i] = W'($urandom_range(0, 7));
      w      = rr(rv, model_last);
      l      = eff_len(lv, w);
      cut    = -1;
      by_rst = 1'b0;
      if (l >= 2 && $urandom_range(0, 3) == 0) begin
        cut    = $urandom_range(0, l - 2);
        by_rst = ($urandom_range(0, 3) == 0);
      end
      txn(rv, lv, cut, by_rst);
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 2)) step();
      end
    end

    req = '0;
    repeat (4) step();
    chk("queue_drained", exp_q.size(), 0);
    chk("monitor_idle", int'(active), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
